// File: rtl/counter_sequence_checker.sv
// counter_sequence_checker: checks an upstream counter's sequence, counts legal wraps and latches the first fault
module counter_sequence_checker #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              cnt_reset,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [WIDTH-1:0]  err_expected,
  output logic [WIDTH-1:0]  err_actual
);
  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  err_expected_q, err_expected_d;
  logic [WIDTH-1:0]  err_actual_q, err_actual_d;
  logic [WIDTH-1:0]  expected, fault_exp;
  logic              fault;
  always_comb begin
    expected       = prev_q + WIDTH'(1);
    state_d        = state_q;
    prev_d         = prev_q;
    wrap_pulse_d   = 1'b0;
    err_d          = err_q;
    err_expected_d = err_expected_q;
    err_actual_d   = err_actual_q;
    fault          = 1'b0;
    fault_exp      = '0;
    case (state_q)
      INIT: begin
        if (cnt_reset) fault = (q_in != '0);
        else begin
          prev_d  = q_in;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (cnt_reset) begin
          if (q_in == '0) state_d = INIT;
          else fault = 1'b1;
        end else if (q_in == expected) begin
          prev_d       = q_in;
          wrap_pulse_d = &prev_q;
        end else begin
          fault     = 1'b1;
          fault_exp = expected;
        end
      end
      FAULT: begin
        if (clear) begin
          state_d        = INIT;
          err_d          = 1'b0;
          err_expected_d = '0;
          err_actual_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
    if (fault) begin
      err_d          = 1'b1;
      err_expected_d = fault_exp;
      err_actual_d   = q_in;
      state_d        = FAULT;
    end
    wrap_count_d = clear ? '0
                 : (wrap_pulse_d && !(&wrap_count_q)) ? wrap_count_q + WRAP_W'(1)
                 : wrap_count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= INIT;
      prev_q         <= '0;
      wrap_pulse_q   <= 1'b0;
      wrap_count_q   <= '0;
      err_q          <= 1'b0;
      err_expected_q <= '0;
      err_actual_q   <= '0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      wrap_pulse_q   <= wrap_pulse_d;
      wrap_count_q   <= wrap_count_d;
      err_q          <= err_d;
      err_expected_q <= err_expected_d;
      err_actual_q   <= err_actual_d;
    end
  end
  assign locked       = (state_q == TRACK);
  assign wrap_pulse   = wrap_pulse_q;
  assign wrap_count   = wrap_count_q;
  assign err          = err_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;
endmodule

// File: doc/counter_sequence_checker.md
COUNTER_SEQUENCE_CHECKER -- requirements
Module: counter_sequence_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the monitored counter value.
REQ-002 Parameter WRAP_W, default 8: width of the wrap counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 q_in  input  WIDTH  counter value from the upstream ripple counter; it changes on the falling edge of clk.
REQ-006 cnt_reset  input  1  upstream counter's active-high reset level, sampled on rising clk edges.
REQ-007 clear  input  1  synchronous clear of the fault and the wrap count.
REQ-008 locked  output  1  high while state is TRACK.
REQ-009 wrap_pulse  output  1  one-cycle pulse on a legal (2^WIDTH-1)->0 step.
REQ-010 wrap_count  output  WRAP_W  number of legal wraps, saturating.
REQ-011 err  output  1  sticky sequence-fault flag.
REQ-012 err_expected  output  WIDTH  value expected at the first fault.
REQ-013 err_actual  output  WIDTH  value sampled at the first fault.

Function
REQ-014 The block SHALL sample q_in on every rising clk edge; all outputs SHALL be registered, so they reflect a sample one clock after it is taken.
REQ-015 The block SHALL keep a register prev holding the last accepted sample, and SHALL compute expected as (prev+1) mod 2^WIDTH.
REQ-016 The state machine SHALL have the states INIT, TRACK and FAULT.
REQ-017 INIT, cnt_reset=0: prev <= q_in, no check, next state TRACK.
REQ-018 INIT, cnt_reset=1: stay in INIT; a q_in value other than 0 SHALL be a fault (expected=0).
REQ-019 TRACK, cnt_reset=1: q_in=0 gives next state INIT; any other value is a fault with expected=0.
REQ-020 TRACK, cnt_reset=0: q_in==expected gives prev <= q_in and stays in TRACK; any other value (including a hold) is a fault.
REQ-021 On a fault, the block SHALL set err=1, latch err_expected and err_actual, and enter FAULT.
REQ-022 FAULT SHALL ignore q_in and cnt_reset, hold err, err_expected and err_actual, and leave only on clear=1, going to INIT with err, err_expected and err_actual cleared.
REQ-023 wrap_pulse SHALL be 1 for exactly one cycle after a TRACK step from prev=2^WIDTH-1 to q_in=0 with cnt_reset=0.
REQ-024 A step to 0 caused by cnt_reset SHALL NOT count as a wrap.
REQ-025 wrap_count SHALL increment on each wrap_pulse and saturate at 2^WRAP_W-1.
REQ-026 clear=1 SHALL zero wrap_count in any state.
REQ-027 If clear and a legal wrap coincide, wrap_pulse SHALL still assert and wrap_count SHALL become 0 (clear wins).
REQ-028 clear in INIT or TRACK SHALL NOT change the state; the sequence check still applies to that cycle's sample.
REQ-029 If clear and a fault coincide in TRACK, the fault SHALL be recorded (clear acts only on state present before the edge).
REQ-030 locked SHALL equal (state==TRACK).

Reset
REQ-031 reset=0 SHALL asynchronously force state=INIT, prev=0, locked=0, wrap_pulse=0, wrap_count=0, err=0, err_expected=0 and err_actual=0.
REQ-032 When reset is released mid-sequence, the first rising edge with reset=1 SHALL be treated as INIT.
REQ-033 No output SHALL glitch while reset=0.

Verification
REQ-034 reset low 15 ns, then a free-running counter with cnt_reset=0 -> locked=1 one cycle after the first sample; err stays 0 for 40 cycles; wrap_pulse asserts once every 16 cycles; wrap_count=2 after two 15->0 steps.
REQ-035 Skipped count (q_in 5->7) -> err=1, err_expected=5'd6 truncated to WIDTH (6), err_actual=7, locked=0; clear=1 for one cycle -> err=0, state INIT, then TRACK on the next sample.
REQ-036 cnt_reset high for 2 cycles with q_in=0 in TRACK at prev=9 -> no err, no wrap_pulse, wrap_count unchanged; after release the first value is accepted unchecked and the count resumes.
REQ-037 cnt_reset=1 while q_in=3 -> err=1, err_expected=0, err_actual=3.
REQ-038 WRAP_W=2 with 5 legal wraps -> wrap_count saturates at 3; clear coinciding with the 15->0 step -> wrap_pulse=1 and wrap_count=0.
REQ-039 reset pulsed low mid-TRACK with err=1 -> all outputs 0 immediately (without waiting for a clk edge); relock on the first sample after release.
